// File: rtl/branch_predictor_table.sv
// Table of CTR_BITS-wide direction counters indexed by PC (optionally
// XORed with a global history register). Predictions are registered one
// cycle after the request; resolved branches train the entry they came from.
module branch_predictor_table #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int PC_LSB     = 2,
  parameter int MODE       = 0,
  parameter int RESET_CTR  = (1 << (CTR_BITS - 1)) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [XLEN-1:0]       pred_pc,
  output logic                  pred_resp_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(RESET_CTR);

  logic [CTR_BITS-1:0]   ctr_q [DEPTH];
  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_next;
  logic [INDEX_BITS-1:0] hist;
  logic [INDEX_BITS-1:0] idx;

  // PC bits outside the index slice do not influence the prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pred_pc;

  assign idx = pred_pc[PC_LSB +: INDEX_BITS] ^ hist;

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr_q;
      logic [GHR_BITS-1:0] ghr_next;

      if (GHR_BITS == 1) begin : g_one
        assign ghr_next = upd_taken;
      end else begin : g_many
        assign ghr_next = {ghr_q[GHR_BITS-2:0], upd_taken};
      end

      // History is trained only by resolved branches, newest outcome in LSB.
      always_ff @(posedge clk) begin
        if (!reset)         ghr_q <= '0;
        else if (upd_valid) ghr_q <= ghr_next;
      end

      assign hist = INDEX_BITS'(ghr_q);
    end else begin : g_no_ghr
      assign hist = '0;
    end
  endgenerate

  // Next value of the counter being trained, per the selected policy.
  always_comb begin
    // NOTE: defaults first so every path assigns ctr_next and no latch is inferred.
    ctr_cur  = ctr_q[upd_index];
    ctr_next = ctr_cur;
    if (MODE == 1) begin
      // Hysteresis: strong states need two mispredicts to flip.
      if (upd_taken) ctr_next = (ctr_cur == '0) ? CTR_BITS'(1) : CTR_MAX;
      else           ctr_next = (ctr_cur == CTR_MAX) ? CTR_BITS'(2) : '0;
    end else begin
      if (upd_taken && ctr_cur != CTR_MAX)  ctr_next = ctr_cur + CTR_BITS'(1);
      else if (!upd_taken && ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
    end
  end

  // Counter table: every entry returns to weakly-not-taken on reset.
  always_ff @(posedge clk) begin
    // NOTE: the table is explicitly reset because predictions must be
    // deterministic straight after reset; this rules out a RAM macro.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr_q[upd_index] <= ctr_next;
    end
  end

  // Registered prediction; reads pre-update state, no bypass from training.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_index      <= '0;
    end else begin
      pred_resp_valid <= pred_valid;
      if (pred_valid) begin
        pred_index <= idx;
        pred_taken <= ctr_q[idx][CTR_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: three instances (bimodal saturating,
// bimodal hysteresis, gshare saturating) share one stimulus stream and are
// compared every cycle against a table-of-integers reference model.
module tb_branch_predictor_table;

  localparam int NDUT = 3;
  localparam int IB   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        upd_valid = 1'b0;
  logic [IB-1:0] upd_index = '0;
  logic        upd_taken = 1'b0;

  logic          resp_v  [NDUT];
  logic          taken_o [NDUT];
  logic [IB-1:0] idx_o   [NDUT];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_predictor_table #(.XLEN(32), .INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(0),
                           .PC_LSB(2), .MODE(0)) u_bim (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(resp_v[0]), .pred_taken(taken_o[0]), .pred_index(idx_o[0]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken));

  branch_predictor_table #(.XLEN(32), .INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(0),
                           .PC_LSB(2), .MODE(1)) u_hys (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(resp_v[1]), .pred_taken(taken_o[1]), .pred_index(idx_o[1]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken));

  branch_predictor_table #(.XLEN(32), .INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(4),
                           .PC_LSB(2), .MODE(0)) u_gsh (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(resp_v[2]), .pred_taken(taken_o[2]), .pred_index(idx_o[2]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken));

  // Reference model state, one row per instance.
  int m_ctr [NDUT][16];
  int m_ghr [NDUT];
  int m_v   [NDUT];
  int m_t   [NDUT];
  int m_i   [NDUT];
  int m_mode [NDUT] = '{0, 1, 0};
  int m_hist [NDUT] = '{0, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit r, input bit pv, input logic [31:0] pc,
                            input bit uv, input int ui, input bit ut);
    for (int k = 0; k < NDUT; k++) begin
      if (!r) begin
        for (int e = 0; e < 16; e++) m_ctr[k][e] = 1;
        m_ghr[k] = 0; m_v[k] = 0; m_t[k] = 0; m_i[k] = 0;
      end else begin
        if (pv) begin
          int ix;
          ix = int'((pc >> 2) & 32'hF) ^ (m_hist[k] != 0 ? m_ghr[k] : 0);
          m_v[k] = 1;
          m_i[k] = ix;
          m_t[k] = (m_ctr[k][ix] >= 2) ? 1 : 0;
        end else begin
          m_v[k] = 0;
        end
        if (uv) begin
          int c;
          c = m_ctr[k][ui];
          if (m_mode[k] == 0) c = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
          else                c = ut ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
          m_ctr[k][ui] = c;
          if (m_hist[k] != 0) m_ghr[k] = ((m_ghr[k] << 1) | int'(ut)) & 15;
        end
      end
    end
  endtask

  // Drive one cycle, then compare every instance against the model.
  task automatic cycle(input bit r, input bit pv, input logic [31:0] pc,
                       input bit uv, input int ui, input bit ut);
    reset = r; pred_valid = pv; pred_pc = pc;
    upd_valid = uv; upd_index = IB'(ui); upd_taken = ut;
    @(posedge clk);
    #1;
    model_step(r, pv, pc, uv, ui, ut);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d resp_valid", k), int'(resp_v[k]), m_v[k]);
      check($sformatf("dut%0d taken", k), int'(taken_o[k]), m_t[k]);
      check($sformatf("dut%0d index", k), int'(idx_o[k]), m_i[k]);
    end
  endtask

  typedef struct {
    bit rst; bit pv; logic [31:0] pc; bit uv; int ui; bit ut;
    int ev; int et; int ei;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit pv, logic [31:0] pc, bit uv, int ui, bit ut,
                              int ev, int et, int ei);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut;
    v.ev = ev; v.et = et; v.ei = ei;
    return v;
  endfunction

  initial begin
    // Hand-derived expectations for the bimodal saturating instance.
    vecs.push_back(mk(0, 1, 32'h14, 1, 5, 1, 0, 0, 0));   // reset beats requests
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0, 1, 0, 5));   // first predict
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0, 5));   // idle: valid drops, index holds
    vecs.push_back(mk(1, 0, 32'h0,  1, 5, 1, 0, 0, 5));   // ctr 2
    vecs.push_back(mk(1, 0, 32'h0,  1, 5, 1, 0, 0, 5));   // ctr 3
    vecs.push_back(mk(1, 0, 32'h0,  1, 5, 1, 0, 0, 5));   // saturates at 3
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0, 1, 1, 5));
    vecs.push_back(mk(1, 0, 32'h0,  1, 5, 0, 0, 1, 5));   // ctr 2, taken holds
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0, 1, 1, 5));
    vecs.push_back(mk(1, 0, 32'h0,  1, 5, 0, 0, 1, 5));   // ctr 1
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0, 1, 0, 5));
    vecs.push_back(mk(1, 0, 32'h0,  1, 0, 0, 0, 0, 5));   // idx0 ctr 0
    vecs.push_back(mk(1, 0, 32'h0,  1, 0, 0, 0, 0, 5));   // stays 0
    vecs.push_back(mk(1, 1, 32'h0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 32'h14, 1, 5, 1, 1, 0, 5));   // collision reads old ctr 1
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0, 1, 1, 5));   // now ctr 2
    vecs.push_back(mk(1, 1, 32'hFFFF_FF17, 0, 0, 0, 1, 1, 5)); // unused PC bits ignored

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      check($sformatf("vec%0d bim valid", i), int'(resp_v[0]), vecs[i].ev);
      check($sformatf("vec%0d bim taken", i), int'(taken_o[0]), vecs[i].et);
      check($sformatf("vec%0d bim index", i), int'(idx_o[0]), vecs[i].ei);
    end

    // Hysteresis walk on idx 5: 1 -T-> 3 -N-> 2 -N-> 0 -T-> 1.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 5, 1);
    cycle(1, 1, 32'h14, 0, 0, 0); check("hys ctr3", int'(taken_o[1]), 1);
    cycle(1, 0, 0, 1, 5, 0);
    cycle(1, 1, 32'h14, 0, 0, 0); check("hys ctr2", int'(taken_o[1]), 1);
    cycle(1, 0, 0, 1, 5, 0);
    cycle(1, 1, 32'h14, 0, 0, 0); check("hys ctr0", int'(taken_o[1]), 0);
    cycle(1, 0, 0, 1, 5, 1);
    cycle(1, 1, 32'h14, 0, 0, 0); check("hys ctr1", int'(taken_o[1]), 0);

    // Gshare: T,T,N,T gives history 1101, so pc 0x14 maps to 5^D = 8.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 2, 0);
    cycle(1, 0, 0, 1, 3, 1);
    cycle(1, 1, 32'h14, 0, 0, 0); check("gsh index", int'(idx_o[2]), 8);
    // Colliding predict still sees 1101; afterwards history is 1011 -> 5^B = E.
    cycle(1, 1, 32'h14, 1, 9, 1); check("gsh collide old ghr", int'(idx_o[2]), 8);
    cycle(1, 1, 32'h14, 0, 0, 0); check("gsh new ghr", int'(idx_o[2]), 14);

    // Reset mid-operation drops the in-flight response and clears training.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 5, 1);
    cycle(1, 0, 0, 1, 5, 1);
    cycle(1, 1, 32'h14, 0, 0, 0); check("pre-reset taken", int'(taken_o[0]), 1);
    cycle(0, 1, 32'h14, 1, 5, 1); check("reset drops resp", int'(resp_v[0]), 0);
    cycle(1, 1, 32'h14, 0, 0, 0);
    check("post-reset taken", int'(taken_o[0]), 0);
    check("post-reset gsh index", int'(idx_o[2]), 5);

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
